// File: rtl/cpu_load_run_ctrl.sv
// Program loader / run controller: streams loader bytes into program memory
// until a run of all-ones bytes, then runs until the fetched instruction is
// the all-ones halt word.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | one-cycle settle after reset, loader input ignored
// LOAD  | accepting loader bytes, writing them to program memory
// RUN   | program executing, watching IM_inst for the halt word
// DONE  | halt instruction seen, o_is_done held until restart/reset
// OVF   | load ran past the last address, o_error held until restart/reset
module cpu_load_run_ctrl #(
    parameter int DATA_W  = 8,
    parameter int INST_W  = 16,
    parameter int END_CNT = 2,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_inst,
    input  logic [INST_W-1:0] IM_inst,
    input  logic              i_restart,
    output logic              inCmd,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [ADDR_W:0]   o_load_cnt,
    output logic              o_is_done,
    output logic              o_error
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_OVF  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [3:0]        RUN_END  = 4'(END_CNT);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        run_cnt;
    logic              accept;
    logic              clear_load;
    logic              byte_ones;
    logic              term_hit;
    logic              at_top;

    // Next-state decode plus the accept/clear strobes used by the datapath.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        clear_load = 1'b0;
        byte_ones  = &i_inst;
        // The run counter never exceeds END_CNT-1 while loading, so +1 cannot wrap.
        term_hit   = byte_ones && ((run_cnt + 4'd1) == RUN_END);
        at_top     = &addr;
        case (state)
            S_INIT: state_nxt = S_LOAD;
            S_LOAD: begin
                if (i_valid) begin
                    accept = 1'b1;
                    if (term_hit) begin
                        state_nxt = S_RUN;
                    end else if (at_top) begin
                        state_nxt = S_OVF;
                    end
                end
            end
            S_RUN: begin
                if (i_restart) begin
                    state_nxt  = S_LOAD;
                    clear_load = 1'b1;
                end else if (&IM_inst) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE, S_OVF: begin
                if (i_restart) begin
                    state_nxt  = S_LOAD;
                    clear_load = 1'b1;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Load datapath: registered write port, address, byte count and terminator run.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_load_cnt <= '0;
            addr       <= '0;
            run_cnt    <= '0;
        end else begin
            o_wr_en <= accept;
            if (accept) begin
                o_wr_addr  <= addr;
                o_wr_data  <= i_inst;
                addr       <= addr + ADDR_ONE;
                o_load_cnt <= o_load_cnt + CNT_ONE;
                run_cnt    <= byte_ones ? (run_cnt + 4'd1) : 4'd0;
            end else if (clear_load) begin
                addr       <= '0;
                o_load_cnt <= '0;
                run_cnt    <= '0;
            end
        end
    end

    assign inCmd     = (state != S_RUN) && (state != S_DONE);
    assign o_is_done = (state == S_DONE);
    assign o_error   = (state == S_OVF);

endmodule

// File: doc/cpu_load_run_ctrl.md
CPU_LOAD_RUN_CTRL -- requirements
Module: cpu_load_run_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of loader byte i_inst.
REQ-002 Parameter INST_W, default 16: width of fetched instruction IM_inst.
REQ-003 Parameter END_CNT, default 2 (legal 1..15): number of consecutive all-ones loader bytes that end program load.
REQ-004 Parameter ADDR_W, default 8: width of the program write address.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 i_valid  in  1  i_inst carries a loader byte this cycle.
REQ-008 i_inst  in  DATA_W  loader byte.
REQ-009 IM_inst  in  INST_W  instruction currently fetched from instruction memory.
REQ-010 i_restart  in  1  single-cycle request to re-enter load mode.
REQ-011 inCmd  out  1  high while the block is not in RUN or DONE (load phase active).
REQ-012 o_wr_en  out  1  registered write strobe to program memory.
REQ-013 o_wr_addr  out  ADDR_W  registered write address.
REQ-014 o_wr_data  out  DATA_W  registered write data.
REQ-015 o_load_cnt  out  ADDR_W+1  number of bytes written in the current load.
REQ-016 o_is_done  out  1  program executed its halt instruction.
REQ-017 o_error  out  1  load overflowed the address space.

Function
REQ-018 The FSM SHALL have states INIT, LOAD, RUN, DONE, OVF; outputs SHALL decode from the registered state.
REQ-019 INIT SHALL last exactly one cycle, then go to LOAD unconditionally; i_valid SHALL be ignored in INIT.
REQ-020 In LOAD, each cycle with i_valid=1 SHALL accept the byte and, next cycle, assert o_wr_en=1 with o_wr_data=byte and o_wr_addr=current address; the address and o_load_cnt then increment by 1.
REQ-021 o_wr_en SHALL be 0 in every cycle not following an accepted byte.
REQ-022 A terminator run counter SHALL increment on each accepted all-ones byte and clear on each accepted other byte; cycles with i_valid=0 SHALL leave it unchanged.
REQ-023 When an accepted byte brings the run counter to END_CNT, the state SHALL go to RUN next cycle; terminator bytes SHALL be written like any other byte.
REQ-024 If a byte is accepted at address 2^ADDR_W-1 and does not complete the terminator, the state SHALL go to OVF; that byte SHALL still be written. A byte completing the terminator at that address SHALL go to RUN.
REQ-025 In RUN, inCmd=0; when IM_inst is all-ones, the state SHALL go to DONE next cycle.
REQ-026 o_is_done SHALL be 1 exactly while in DONE; o_error SHALL be 1 exactly while in OVF. Both are sticky until rst or i_restart.
REQ-027 IM_inst SHALL be ignored outside RUN; an all-ones IM_inst during LOAD SHALL NOT set o_is_done.
REQ-028 i_valid SHALL be ignored in RUN, DONE and OVF.
REQ-029 i_restart in RUN, DONE or OVF SHALL move the state to LOAD next cycle and clear address, o_load_cnt and run counter; i_restart in INIT or LOAD SHALL be ignored.
REQ-030 rst SHALL take priority over i_restart and all other inputs.

Reset
REQ-031 While rst=1 at a clock edge: state=INIT, inCmd=1, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_load_cnt=0, run counter=0, o_is_done=0, o_error=0.
REQ-032 rst asserted mid-load or mid-run SHALL discard all progress; no write strobe SHALL issue in the cycle after reset.

Verification
REQ-033 Defaults: rst, then bytes 0x12, 0xFF, 0x34, 0xFF, 0xFF on consecutive i_valid cycles. Required: five writes at addr 0..4, o_load_cnt=5, inCmd falls one cycle after the last byte.
REQ-034 Defaults: load 0xFF, gap of 3 idle cycles, 0xFF. Required: RUN is entered (gaps do not break the run). Then IM_inst=0xFFFF. Required: o_is_done=1 next cycle and held.
REQ-035 ADDR_W=2: four bytes 0x01 with no terminator. Required: writes at 0..3, then o_error=1, inCmd stays 1, and a fifth byte is not written.
REQ-036 Defaults: IM_inst=0xFFFF held from reset through load. Required: o_is_done=0 until one cycle after RUN is entered.
REQ-037 Defaults: from DONE, pulse i_restart. Required: LOAD, o_is_done=0, o_load_cnt=0, and the next byte is written at addr 0. rst during RUN with i_restart=1 gives the INIT values.
REQ-038 END_CNT=3: bytes FF, FF, 00, FF, FF, FF. Required: RUN is entered only after the sixth byte, with o_load_cnt=6.
